// File: rtl/adc_spi_cfg_target.sv
// adc_spi_cfg_target: 3-wire SPI configuration responder with an 8-bit register bank, oversampled in clk.
module adc_spi_cfg_target #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_csbn,
  input  logic                  spi_sclk,
  input  logic                  spi_sdio_in,
  output logic                  spi_sdio_out,
  output logic                  spi_sdio_oe,
  output logic [8*NUM_REGS-1:0] reg_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  frame_err
);
  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, WAIT_CS} state_t;
  state_t                state_q;
  logic [SYNC_STAGES-1:0] cs_q, sclk_q, sdio_q;
  logic                  cs_prev_q, sclk_prev_q;
  logic [3:0]            cnt_q;
  logic [6:0]            sh_q, addr_q;
  logic [7:0]            out_q, sh_d, rd_byte;
  logic [8*NUM_REGS-1:0] reg_q;
  logic                  oe_q, sdo_q, wr_strobe_q, err_q, extra_q;
  logic [6:0]            wr_addr_q;
  logic                  cs, sclk, cs_fall, cs_rise, sc_rise, sc_fall, rd_ok, wr_ok;
  // The synchronizers are deliberately left out of reset so a reset mid-frame does not fake a csbn edge.
  always_ff @(posedge clk) begin
    cs_q        <= {cs_q[SYNC_STAGES-2:0], spi_csbn};
    sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
    sdio_q      <= {sdio_q[SYNC_STAGES-2:0], spi_sdio_in};
    cs_prev_q   <= cs;
    sclk_prev_q <= sclk;
  end
  assign cs      = cs_q[SYNC_STAGES-1];
  assign sclk    = sclk_q[SYNC_STAGES-1];
  assign cs_fall = cs_prev_q & ~cs;
  assign cs_rise = ~cs_prev_q & cs;
  assign sc_rise = ~sclk_prev_q & sclk;
  assign sc_fall = sclk_prev_q & ~sclk;
  assign sh_d    = {sh_q, sdio_q[SYNC_STAGES-1]};
  assign rd_ok   = int'(sh_d[6:0]) < NUM_REGS;
  assign wr_ok   = int'(addr_q) < NUM_REGS;
  assign rd_byte = rd_ok ? reg_q[8*int'(sh_d[6:0]) +: 8] : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      out_q       <= '0;
      reg_q       <= '0;
      oe_q        <= 1'b0;
      sdo_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      extra_q     <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: if (cs_fall) begin
          state_q <= INSTR;
          cnt_q   <= '0;
        end
        INSTR, WDATA, RDATA: if (cs_rise) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
          oe_q    <= 1'b0;
          sdo_q   <= 1'b0;
        end else begin
          if (sc_rise) begin
            sh_q  <= sh_d[6:0];
            cnt_q <= cnt_q + 4'd1;
          end
          if (sc_rise && state_q == INSTR && cnt_q == 4'd7) begin
            addr_q  <= sh_d[6:0];
            state_q <= sh_q[6] ? RDATA : WDATA;
            if (sh_q[6]) begin
              out_q <= rd_byte;
              oe_q  <= 1'b1;
              sdo_q <= rd_byte[7];
            end
          end
          if (sc_rise && cnt_q == 4'd15) begin
            state_q <= WAIT_CS;
            extra_q <= 1'b0;
            oe_q    <= 1'b0;
            sdo_q   <= 1'b0;
            if (state_q == WDATA && wr_ok) begin
              reg_q[8*int'(addr_q) +: 8] <= sh_d;
              wr_strobe_q                <= 1'b1;
              wr_addr_q                  <= addr_q;
            end
          end
          // The MSB is already on the pad, so the fall before the 9th rise must not shift.
          if (sc_fall && state_q == RDATA && cnt_q >= 4'd9) begin
            out_q <= {out_q[6:0], 1'b0};
            sdo_q <= out_q[6];
          end
        end
        WAIT_CS: if (cs_rise) state_q <= IDLE;
          else if (sc_rise && !extra_q) begin
            err_q   <= 1'b1;
            extra_q <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign spi_sdio_out = sdo_q;
  assign spi_sdio_oe  = oe_q;
  assign reg_flat     = reg_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign frame_err    = err_q;
endmodule

// File: tb/tb_adc_spi_cfg_target.sv
// tb_adc_spi_cfg_target: random and directed SPI frames checked through an expectation queue.
module tb_adc_spi_cfg_target;
  localparam int NR = 16;
  localparam int K_WR = 0, K_ERR = 1, K_FRM = 2;
  logic clk = 0, reset = 1, spi_csbn = 1, spi_sclk = 0, spi_sdio_in = 0;
  logic spi_sdio_out, spi_sdio_oe, wr_strobe, frame_err;
  logic [8*NR-1:0] reg_flat;
  logic [6:0] wr_addr;
  typedef struct {int kind; int addr; int data; int oe;} ev_t;
  ev_t q[$];
  logic [7:0] model [NR];
  int total = 0, bad = 0, frm_cnt = 0;
  logic [15:0] obs_oe;
  logic [7:0] obs_rd;

  adc_spi_cfg_target #(.NUM_REGS(NR), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_csbn(spi_csbn), .spi_sclk(spi_sclk),
    .spi_sdio_in(spi_sdio_in), .spi_sdio_out(spi_sdio_out), .spi_sdio_oe(spi_sdio_oe),
    .reg_flat(reg_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  task automatic push(input int k, input int a, input int d, input int o);
    ev_t e;
    e = '{k, a, d, o};
    q.push_back(e);
  endtask

  task automatic bit_cycle(input logic b, output logic oe, output logic so);
    @(negedge clk) spi_sdio_in = b;
    repeat (4) @(negedge clk);
    spi_sclk = 1;
    oe = spi_sdio_oe;
    so = spi_sdio_out;
    repeat (4) @(negedge clk);
    spi_sclk = 0;
  endtask

  // Expectations come from the frame rules and the bank model, queued before the frame is driven.
  task automatic frame(input logic [15:0] w, input int nr);
    int a;
    logic [15:0] op;
    logic [7:0] rd;
    logic o, s;
    a = int'(w[14:8]);
    op = '0;
    rd = '0;
    if (nr < 16) push(K_ERR, 0, 0, 0);
    else begin
      if (!w[15] && a < NR) begin
        model[a] = w[7:0];
        push(K_WR, a, int'(w[7:0]), 0);
      end
      if (nr > 16) push(K_ERR, 0, 0, 0);
      push(K_FRM, a, (w[15] && a < NR) ? int'(model[a]) : 0, w[15] ? 'h00FF : 0);
    end
    spi_csbn = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nr; i++) begin
      bit_cycle(i < 16 ? w[15-i] : 1'b0, o, s);
      if (i < 16) op[15-i] = o;
      if (i >= 8 && i < 16) rd[15-i] = s;
    end
    repeat (4) @(negedge clk);
    spi_csbn = 1;
    repeat (6) @(negedge clk);
    if (nr >= 16) begin
      obs_oe = op;
      obs_rd = rd;
      frm_cnt++;
    end
  endtask

  initial begin
    int seen = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if ((k == K_WR && wr_strobe) || (k == K_ERR && frame_err) || (k == K_FRM && frm_cnt != seen)) begin
          if (k == K_FRM) seen = frm_cnt;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d want none", k);
          end else begin
            e = q.pop_front();
            check("event_kind", k, e.kind);
            if (k == K_WR && e.kind == K_WR) begin
              check("wr_addr", wr_addr, e.addr);
              check("wr_data", reg_flat[8*e.addr +: 8], e.data);
            end
            if (k == K_FRM && e.kind == K_FRM) begin
              check("oe_window", obs_oe, e.oe);
              check("read_data", obs_rd, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic o, s;
    logic [15:0] w;
    int a, nr;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_oe", spi_sdio_oe, 0);
    check("rst_out", spi_sdio_out, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_err", frame_err, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_bank", reg_flat, model_flat());
    frame(16'h03A5, 16);
    check("t1_reg3", reg_flat[31:24], 8'hA5);
    check("t1_bank", reg_flat, model_flat());
    frame(16'h053C, 16);
    frame(16'h8500, 16);
    frame(16'h7FFF, 16);
    frame(16'hFF00, 16);
    check("t3_bank", reg_flat, model_flat());
    frame(16'h0211, 12);
    check("t4_reg2_abort", reg_flat[23:16], 8'h00);
    frame(16'h0211, 16);
    check("t4_reg2", reg_flat[23:16], 8'h11);
    frame(16'h0444, 18);
    frame(16'h8400, 17);
    frame(16'h0977, 16);
    w = 16'h8900;
    spi_csbn = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) bit_cycle(w[15-i], o, s);
    repeat (2) @(negedge clk);
    check("t5_oe_before", spi_sdio_oe, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t5_oe_after", spi_sdio_oe, 0);
    check("t5_out_after", spi_sdio_out, 0);
    check("t5_bank_after", reg_flat, 0);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    spi_csbn = 1;
    repeat (6) @(negedge clk);
    frame(16'h0A5A, 16);
    frame(16'h8A00, 16);
    frame(16'h0001, 16);
    frame(16'h0102, 16);
    frame(16'h0203, 16);
    check("t6_low_regs", reg_flat[23:0], 24'h030201);
    for (int n = 0; n < 40; n++) begin
      a = ($urandom % 4 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, NR - 1));
      w = {1'($urandom), 7'(a), 8'($urandom)};
      nr = ($urandom % 6 == 0) ? int'($urandom_range(0, 18)) : 16;
      frame(w, nr);
    end
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    check("final_bank", reg_flat, model_flat());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
